// File: rtl/stream_dispatch_pkg.sv
// Shared types and constants for the stream dispatcher.
package stream_dispatch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StBcast
    } state_e;

    // Length substituted when a packet is requested with pkt_len == 0.
    localparam int unsigned PKT_LEN_ZERO_SUB = 1;

endpackage

// File: rtl/stream_dispatch_if.sv
// Multi-channel output stream: shared data/last, per-channel valid/ready.
interface stream_dispatch_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 5
);
    logic [DATA_W-1:0] m_tdata;
    logic [NUM_CH-1:0] m_tvalid;
    logic              m_tlast;
    logic [NUM_CH-1:0] m_tready;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/stream_dispatch_fifo.sv
// Power-of-two FIFO with occupancy count, full/empty flags and sticky overflow.
module stream_dispatch_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d   = rd_ptr_q + PTR_W'(rd_en);
        count_d    = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        overflow_d = overflow_q | (push & full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/stream_dispatch.sv
// FIFO-fed packet dispatcher steering beats to one of NUM_CH stream channels.
// Define STREAM_DISPATCH_BROADCAST_EN to enable broadcast of a packet to all channels.
module stream_dispatch
    import stream_dispatch_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_CH = 5,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         din,
    input  logic                      op_en,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CNT_W-1:0]          pkt_len,
    input  logic                      bcast,
    stream_dispatch_if.master         m_axis,
    output logic                      full,
    output logic                      empty,
    output logic [CNT_W-1:0]          count,
    output logic                      overflow,
    output logic                      sel_err
);
    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              sel_err_q, sel_err_d;
    logic [NUM_CH-1:0] valid;
    logic              pop;
    logic              last_beat;
    logic              bcast_req;
    logic              sel_bad;
    logic [DATA_W-1:0] fifo_dout;

`ifdef STREAM_DISPATCH_BROADCAST_EN
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] hs_v;
    assign bcast_req = bcast;
`else
    logic unused_bcast;
    assign unused_bcast = bcast;
    assign bcast_req    = 1'b0;
`endif

    stream_dispatch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (din),
        .pop      (pop),
        .dout     (fifo_dout),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    assign sel_bad   = (32'(sel) >= NUM_CH);
    assign last_beat = (beat_q == len_q - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        len_d     = len_q;
        beat_d    = beat_q;
        sel_err_d = 1'b0;
        valid     = '0;
        pop       = 1'b0;
`ifdef STREAM_DISPATCH_BROADCAST_EN
        done_d    = done_q;
        hs_v      = '0;
`endif
        case (state_q)
            StIdle: begin
                if (op_en && !empty) begin
                    if (!bcast_req && sel_bad) begin
                        sel_err_d = 1'b1;
                    end else begin
                        sel_d   = sel;
                        len_d   = (pkt_len == '0) ? CNT_W'(PKT_LEN_ZERO_SUB) : pkt_len;
                        beat_d  = '0;
                        state_d = bcast_req ? StBcast : StSend;
                    end
                end
            end
            StSend: begin
                valid[sel_q] = ~empty;
                if (valid[sel_q] && m_axis.m_tready[sel_q]) begin
                    pop = 1'b1;
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
`ifdef STREAM_DISPATCH_BROADCAST_EN
            StBcast: begin
                valid = {NUM_CH{~empty}} & ~done_q;
                hs_v  = valid & m_axis.m_tready;
                // The word retires only once every channel has taken it.
                if (!empty && (&(done_q | hs_v))) begin
                    pop    = 1'b1;
                    done_d = '0;
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end else begin
                    done_d = done_q | hs_v;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            len_q     <= CNT_W'(PKT_LEN_ZERO_SUB);
            beat_q    <= '0;
            sel_err_q <= 1'b0;
`ifdef STREAM_DISPATCH_BROADCAST_EN
            done_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            sel_err_q <= sel_err_d;
`ifdef STREAM_DISPATCH_BROADCAST_EN
            done_q    <= done_d;
`endif
        end
    end

    assign m_axis.m_tvalid = valid;
    assign m_axis.m_tdata  = fifo_dout;
    assign m_axis.m_tlast  = (|valid) & last_beat;
    assign sel_err         = sel_err_q;

endmodule

// File: tb/tb_stream_dispatch.sv
// Directed and randomized checks of stream_dispatch against a queue-based packet model.
// Broadcast checks are compiled when STREAM_DISPATCH_BROADCAST_EN is defined.
module tb_stream_dispatch;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned NUM_CH = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] din;
    logic       op_en;
    logic [2:0] sel;
    logic [4:0] pkt_len;
    logic       bcast;
    logic       full, empty, overflow, sel_err;
    logic [4:0] count;

    stream_dispatch_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    stream_dispatch #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (din),
        .op_en    (op_en),
        .sel      (sel),
        .pkt_len  (pkt_len),
        .bcast    (bcast),
        .m_axis   (bus),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] model_q[$];
    bit         ovf_m;
    beat_t      mon_q[$];
    logic [4:0] stall_prev;
    logic [7:0] d_prev;
    logic       l_prev;
    int         stall_viol = 0;

    // Records every completed handshake and flags any stalled beat that changes.
    always @(negedge clk) begin : mon
        beat_t b;
        if (rst) begin
            stall_prev = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (stall_prev[i] && (!bus.m_tvalid[i] || bus.m_tdata !== d_prev ||
                                      bus.m_tlast !== l_prev)) begin
                    stall_viol++;
                end
                if (bus.m_tvalid[i] && bus.m_tready[i]) begin
                    b.ch   = 3'(i);
                    b.data = bus.m_tdata;
                    b.last = bus.m_tlast;
                    mon_q.push_back(b);
                end
            end
            stall_prev = bus.m_tvalid & ~bus.m_tready;
            d_prev     = bus.m_tdata;
            l_prev     = bus.m_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic push_word(input logic [7:0] d);
        push = 1'b1;
        din  = d;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else ovf_m = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic start_pkt(input int s, input int len, input bit bc);
        op_en   = 1'b1;
        sel     = 3'(s);
        pkt_len = 5'(len);
        bcast   = bc;
        tick();
        op_en   = 1'b0;
        bcast   = 1'b0;
    endtask

    // Expects one packet of len beats (0 means 1) on channel ch, data in FIFO order.
    task automatic expect_pkt(input string tag, input int ch, input int len, input bit rnd);
        int n;
        n = (len == 0) ? 1 : len;
        for (int c = 0; c < 500 && mon_q.size() < n; c++) begin
            if (rnd) bus.m_tready = 5'($urandom);
            tick();
        end
        bus.m_tready = '1;
        check({tag, " beats"}, 32'(mon_q.size() >= n), 1);
        for (int j = 0; j < n; j++) begin
            beat_t      b;
            logic [7:0] e;
            if (mon_q.size() == 0) break;
            b = mon_q.pop_front();
            e = model_q.pop_front();
            check({tag, " ch"}, b.ch, ch);
            check({tag, " data"}, b.data, e);
            check({tag, " last"}, b.last, (j == n - 1));
        end
    endtask

    task automatic check_idle(input string tag);
        tick();
        tick();
        check({tag, " extra beats"}, mon_q.size(), 0);
        check({tag, " count"}, count, model_q.size());
        check({tag, " empty"}, empty, (model_q.size() == 0));
        mon_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, len, n;
        rst = 1'b1; push = 1'b0; din = '0; op_en = 1'b0; sel = '0; pkt_len = '0;
        bcast = 1'b0; bus.m_tready = '1; ovf_m = 1'b0;
        #2;
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst count", count, 0);
        check("rst overflow", overflow, 0);
        check("rst sel_err", sel_err, 0);
        check("rst tvalid", bus.m_tvalid, 0);
        check("rst tlast", bus.m_tlast, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single packet to channel 2.
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        start_pkt(2, 3, 0);
        expect_pkt("single", 2, 3, 0);
        check_idle("single");

        // Latency from first push into an empty FIFO.
        push = 1'b1; din = 8'hA5; model_q.push_back(8'hA5);
        tick();
        push = 1'b0; op_en = 1'b1; sel = 3'd1; pkt_len = 5'd1;
        check("lat k valid", bus.m_tvalid, 0);
        tick();
        op_en = 1'b0;
        check("lat k+1 valid", bus.m_tvalid, 5'b00010);
        check("lat k+1 tlast", bus.m_tlast, 1);
        expect_pkt("latency", 1, 1, 0);
        check_idle("latency");

        // Back-to-back packets with op_en held: one bubble cycle between them.
        for (int i = 0; i < 4; i++) push_word(8'(8'h40 + i));
        op_en = 1'b1; sel = 3'd0; pkt_len = 5'd2;
        tick();
        check("b2b beat0 valid", bus.m_tvalid, 5'b00001);
        check("b2b beat0 tlast", bus.m_tlast, 0);
        tick();
        check("b2b beat1 tlast", bus.m_tlast, 1);
        tick();
        check("b2b bubble", bus.m_tvalid, 0);
        tick();
        op_en = 1'b0;
        check("b2b restart", bus.m_tvalid, 5'b00001);
        expect_pkt("b2b pkt0", 0, 2, 0);
        expect_pkt("b2b pkt1", 0, 2, 0);
        check_idle("b2b");

        // Overflow with no pops.
        for (int i = 0; i < 17; i++) begin
            push_word(8'($urandom));
            if (i == 14) check("ovf full@15", full, 0);
            if (i == 15) begin
                check("ovf full@16", full, 1);
                check("ovf count@16", count, 16);
                check("ovf flag@16", overflow, 0);
            end
            if (i == 16) begin
                check("ovf flag@17", overflow, 1);
                check("ovf count@17", count, 16);
            end
        end
        start_pkt(4, 16, 0);
        expect_pkt("ovf drain", 4, 16, 1);
        check_idle("ovf drain");
        check("ovf sticky", overflow, ovf_m);

        // Out-of-range select is rejected.
        push_word(8'h5A); push_word(8'hC3);
        op_en = 1'b1; sel = 3'd7; pkt_len = 5'd2; bcast = 1'b0;
        tick();
        op_en = 1'b0;
        check("selerr pulse", sel_err, 1);
        check("selerr valid", bus.m_tvalid, 0);
        check("selerr count", count, 2);
        tick();
        check("selerr one cycle", sel_err, 0);
        check("selerr still idle", bus.m_tvalid, 0);
        start_pkt(0, 2, 0);
        expect_pkt("selerr after", 0, 2, 0);
        check_idle("selerr");

        // Backpressure: ready on ch1 toggles every cycle.
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        bus.m_tready = '0;
        start_pkt(1, 4, 0);
        for (int c = 0; c < 40 && mon_q.size() < 4; c++) begin
            bus.m_tready = (c % 2 == 0) ? 5'b00010 : 5'b00000;
            tick();
        end
        expect_pkt("bp", 1, 4, 0);
        check_idle("bp");
        check("bp stable", stall_viol, 0);

        // Reset after two beats of a four-beat packet.
        for (int i = 0; i < 4; i++) push_word(8'(8'h90 + i));
        start_pkt(3, 4, 0);
        tick();
        tick();
        check("rstmid beats", mon_q.size(), 2);
        bus.m_tready = '0;
        #1;
        rst = 1'b1;
        #1;
        check("rstmid valid", bus.m_tvalid, 0);
        check("rstmid tlast", bus.m_tlast, 0);
        check("rstmid count", count, 0);
        check("rstmid empty", empty, 1);
        check("rstmid overflow", overflow, 0);
        model_q.delete();
        mon_q.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.m_tready = '1;
        tick();
        push_word(8'hE1); push_word(8'hE2);
        start_pkt(1, 2, 0);
        expect_pkt("post rst", 1, 2, 0);
        check_idle("post rst");

`ifdef STREAM_DISPATCH_BROADCAST_EN
        begin
            logic [4:0] seen;
            beat_t      b;
            logic [7:0] w0, w1;
            push_word(8'h3C); push_word(8'hC7);
            w0 = model_q.pop_front();
            w1 = model_q.pop_front();
            bus.m_tready = 5'b10111;
            start_pkt(0, 2, 1);
            check("bc all valid", bus.m_tvalid, 5'b11111);
            check("bc tlast0", bus.m_tlast, 0);
            for (int c = 0; c < 4; c++) begin
                tick();
                check("bc wait valid", bus.m_tvalid, 5'b01000);
                check("bc wait count", count, 2);
            end
            tick();
            bus.m_tready = '1;
            tick();
            check("bc pop count", count, 1);
            check("bc beat1 valid", bus.m_tvalid, 5'b11111);
            check("bc beat1 tlast", bus.m_tlast, 1);
            tick();
            check("bc beats", mon_q.size(), 10);
            seen = '0;
            for (int j = 0; j < 10 && mon_q.size() > 0; j++) begin
                b = mon_q.pop_front();
                check("bc data", b.data, (j < 5) ? w0 : w1);
                check("bc last", b.last, (j >= 5));
                if (j < 5) seen[b.ch] = 1'b1;
            end
            check("bc channels", seen, 5'b11111);
            check_idle("bc");
        end
`else
        // Without broadcast, bcast=1 follows sel alone.
        push_word(8'h3C); push_word(8'hC7);
        start_pkt(3, 2, 1);
        expect_pkt("bcast ignored", 3, 2, 0);
        check_idle("bcast ignored");
`endif

        // Randomized packets against the queue model.
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 6);
            if (model_q.size() + n > DEPTH) n = DEPTH - model_q.size();
            for (int i = 0; i < n; i++) push_word(8'($urandom));
            if (model_q.size() == 0) continue;
            len = $urandom_range(0, model_q.size());
            s   = $urandom_range(0, NUM_CH - 1);
            start_pkt(s, len, 0);
            expect_pkt("rand", s, len, 1);
            check_idle("rand");
        end
        if (model_q.size() > 0) begin
            len = model_q.size();
            start_pkt(2, len, 0);
            expect_pkt("rand drain", 2, len, 1);
            check_idle("rand drain");
        end
        check("stall stability", stall_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
